// File: rtl/aes3_tx.sv
// AES3 transmitter: stereo PCM in, biphase-mark line out with preambles and channel status.
// Build option AES3_TX_UNDERFLOW_MUTE_EN: an underflow frame sends silence flagged V=1.
module aes3_tx #(
  parameter int          CLK_PER_UI = 2,
  parameter logic [7:0]  CS_BYTE0   = 8'h01
) (
  input  logic        mck,
  input  logic        reset,
  input  logic [23:0] sample_l,
  input  logic [23:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        aes3,
  output logic        block_start,
  output logic        underflow
);

  localparam int DW = (CLK_PER_UI > 1) ? $clog2(CLK_PER_UI) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_PER_UI - 1);

  // Preamble transitions per UI (bit i = toggle entering UI i).
  localparam logic [7:0] PRE_Z = 8'h39;
  localparam logic [7:0] PRE_X = 8'hC9;
  localparam logic [7:0] PRE_Y = 8'h69;

  logic [DW-1:0] div_cnt;
  logic [6:0]    ui_cnt;
  logic [7:0]    fcnt;
  logic          full;
  logic [23:0]   hold_l;
  logic [23:0]   hold_r;
  logic [23:0]   tx_l;
  logic [23:0]   tx_r;
  logic          tx_v;
  logic          cur_c;
  logic          cur_z;
  logic          line;

  logic          tick;
  logic          load;
  logic          accept;
  logic [6:0]    nxt_ui;
  logic [5:0]    pos;
  logic [4:0]    slot;
  logic [4:0]    bit_idx;
  logic [23:0]   smp;
  logic          par;
  logic [27:0]   word;
  logic [7:0]    pre;
  logic          toggle;

  assign tick   = (div_cnt == DIV_LAST);
  assign load   = tick && (ui_cnt == 7'd127) && !reset;
  assign accept = sample_valid && !full;

  assign sample_ready = !full;
  assign aes3         = line;
  assign block_start  = load && (fcnt == 8'd0);
  assign underflow    = load && !full;

  // Line level for the UI being entered at the next tick.
  always_comb begin
    nxt_ui  = ui_cnt + 7'd1;
    pos     = nxt_ui[5:0];
    slot    = pos[5:1];
    bit_idx = slot - 5'd4;
    smp     = nxt_ui[6] ? tx_r : tx_l;
    par     = ^{smp, tx_v, cur_c};
    word    = {par, cur_c, 1'b0, tx_v, smp};
    pre     = nxt_ui[6] ? PRE_Y : (cur_z ? PRE_Z : PRE_X);
    toggle  = 1'b1;
    if (slot < 5'd4) begin
      toggle = pre[pos[2:0]];
    end else if (pos[0]) begin
      toggle = word[bit_idx];
    end
  end

  always_ff @(posedge mck) begin
    if (reset) begin
      div_cnt <= DIV_LAST;
      ui_cnt  <= 7'd127;
      fcnt    <= 8'd0;
      full    <= 1'b0;
      hold_l  <= '0;
      hold_r  <= '0;
      tx_l    <= '0;
      tx_r    <= '0;
      tx_v    <= 1'b0;
      cur_c   <= 1'b0;
      cur_z   <= 1'b0;
      line    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        ui_cnt <= nxt_ui;
        line   <= line ^ toggle;
      end
      if (accept) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
        full   <= 1'b1;
      end
      if (load) begin
        fcnt  <= (fcnt == 8'd191) ? 8'd0 : fcnt + 8'd1;
        cur_z <= (fcnt == 8'd0);
        cur_c <= (fcnt < 8'd8) ? CS_BYTE0[fcnt[2:0]] : 1'b0;
        if (full) begin
          tx_l <= hold_l;
          tx_r <= hold_r;
          tx_v <= 1'b0;
          full <= 1'b0;
        end else begin
`ifdef AES3_TX_UNDERFLOW_MUTE_EN
          tx_l <= '0;
          tx_r <= '0;
          tx_v <= 1'b1;
`else
          tx_v <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_aes3_tx.sv
// Bench for aes3_tx: frame-level model plus line decoder, directed table and random streams.
module tb_aes3_tx;

  localparam int         CPU = 2;
  localparam int         FRM = 128 * CPU;
  localparam logic [7:0] CS  = 8'h05;

  logic        mck = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        aes3;
  logic        block_start;
  logic        underflow;

  aes3_tx #(.CLK_PER_UI(CPU), .CS_BYTE0(CS)) dut (
    .mck(mck), .reset(reset),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .aes3(aes3), .block_start(block_start), .underflow(underflow)
  );

  always #5 mck = ~mck;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
    logic        c;
    logic        z;
  } frame_t;

  typedef struct packed {
    logic        give;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] el;
    logic [23:0] er;
    logic        ev;
    logic        euf;
  } vec_t;

  int checks = 0;
  int failures = 0;

  frame_t      exp_q[$];
  int          cyc = 0;
  bit          m_full = 0;
  logic [23:0] m_hl = '0, m_hr = '0, m_pl = '0, m_pr = '0;
  int          m_fn = 0;
  bit          rst_prev = 0;
  logic        lv[128];
  logic        prev_lvl = 1'b0;
  frame_t      dec_last;
  logic        dec_z = 1'b0;
  int          dec_count = 0;
  int          bs_count = 0;
  int          uf_count = 0;
  logic        last_uf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode one captured frame of 128 UI levels and compare with the model.
  task automatic decode_frame();
    frame_t      e, d;
    logic        prior;
    logic [27:0] w;
    logic [7:0]  pat;
    logic [7:0]  zpat;
    logic        ok_pre, ok_tr, is_z;
    int          base;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL frame_queue: got empty expected one frame (cyc %0d)", cyc);
      return;
    end
    e = exp_q.pop_front();
    d = '0;
    prior = prev_lvl;
    zpat = 8'b11101000;
    is_z = 1'b1;
    for (int i = 0; i < 8; i++)
      if (lv[i] !== (zpat[7-i] ^ prior)) is_z = 1'b0;
    for (int sub = 0; sub < 2; sub++) begin
      base = sub * 64;
      if (sub == 1) pat = 8'b11100100;
      else if (e.z) pat = 8'b11101000;
      else pat = 8'b11100010;
      ok_pre = 1'b1;
      for (int i = 0; i < 8; i++)
        if (lv[base+i] !== (pat[7-i] ^ prior)) ok_pre = 1'b0;
      chk(sub ? "preamble_y" : "preamble_zx", 32'(ok_pre), 32'd1);
      ok_tr = 1'b1;
      w = '0;
      for (int s = 4; s < 32; s++) begin
        if (lv[base+2*s] === lv[base+2*s-1]) ok_tr = 1'b0;
        w[s-4] = lv[base+2*s] ^ lv[base+2*s+1];
      end
      chk("slot_transition", 32'(ok_tr), 32'd1);
      chk("parity_even", 32'(^w), 32'd0);
      chk(sub ? "audio_r" : "audio_l", 32'(w[23:0]), 32'(sub ? e.r : e.l));
      chk("v_bit", 32'(w[24]), 32'(e.v));
      chk("u_bit", 32'(w[25]), 32'd0);
      chk("c_bit", 32'(w[26]), 32'(e.c));
      if (sub == 0) d.l = w[23:0];
      else d.r = w[23:0];
      d.v = w[24];
      d.c = w[26];
      prior = lv[base+63];
    end
    d.z = is_z;
    prev_lvl = lv[127];
    dec_last = d;
    dec_z = is_z;
    dec_count++;
  endtask

  task automatic step(input logic r_in, input logic v,
                      input logic [23:0] l, input logic [23:0] r);
    bit     load, acc;
    frame_t f;
    int     idx, pos;
    logic [7:0] csv;
    reset = r_in;
    sample_valid = v;
    sample_l = l;
    sample_r = r;
    #1;
    if (underflow) uf_count++;
    if (block_start) bs_count++;
    last_uf = underflow;
    if (r_in) begin
      if (rst_prev) begin
        chk("aes3_in_reset", 32'(aes3), 32'd0);
        chk("ready_in_reset", 32'(sample_ready), 32'd1);
      end
      chk("underflow_in_reset", 32'(underflow), 32'd0);
      chk("block_start_in_reset", 32'(block_start), 32'd0);
      cyc = 0;
      m_full = 0;
      m_pl = '0;
      m_pr = '0;
      m_fn = 0;
      prev_lvl = 1'b0;
      exp_q.delete();
    end else begin
      if (rst_prev) begin
        chk("aes3_after_reset", 32'(aes3), 32'd0);
      end else if (cyc >= 1) begin
        idx = cyc - 1;
        pos = (idx % FRM) / CPU;
        if (idx % CPU == 0) begin
          lv[pos] = aes3;
          if (pos == 127) decode_frame();
        end else begin
          chk("aes3_stable_between_ticks", 32'(aes3), 32'(lv[pos]));
        end
      end
      load = (cyc % FRM) == 0;
      chk("sample_ready", 32'(sample_ready), 32'(!m_full));
      chk("underflow", 32'(underflow), 32'(load && !m_full));
      chk("block_start", 32'(block_start), 32'(load && m_fn == 0));
      acc = v && !m_full;
      if (load) begin
        if (m_full) begin
          f.l = m_hl;
          f.r = m_hr;
          f.v = 1'b0;
          m_full = 0;
        end else begin
`ifdef AES3_TX_UNDERFLOW_MUTE_EN
          f.l = '0;
          f.r = '0;
          f.v = 1'b1;
`else
          f.l = m_pl;
          f.r = m_pr;
          f.v = 1'b0;
`endif
        end
        m_pl = f.l;
        m_pr = f.r;
        csv = CS;
        f.c = (m_fn < 8) ? csv[m_fn] : 1'b0;
        f.z = (m_fn == 0);
        exp_q.push_back(f);
        m_fn = (m_fn + 1) % 192;
      end
      if (acc) begin
        m_hl = l;
        m_hr = r;
        m_full = 1;
      end
      cyc++;
    end
    @(posedge mck);
    @(negedge mck);
    rst_prev = r_in;
  endtask

  // mode 0: idle, 1: continuous random stream, 2: sparse random offers
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        1: step(1'b0, 1'b1, 24'($urandom), 24'($urandom));
        2: step(1'b0, ($urandom % 300) == 0, 24'($urandom), 24'($urandom));
        default: step(1'b0, 1'b0, 24'h0, 24'h0);
      endcase
    end
  endtask

  task automatic run_to(input int m);
    for (int i = 0; i < FRM && (cyc % FRM) != m; i++)
      step(1'b0, 1'b0, 24'h0, 24'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, 24'h0);
  endtask

  vec_t tv[6];
  int   dc0;

  initial begin
    tv[0] = '{1'b1, 24'h000001, 24'h800000, 24'h000001, 24'h800000, 1'b0, 1'b0};
    tv[1] = '{1'b1, 24'h123456, 24'h654321, 24'h123456, 24'h654321, 1'b0, 1'b0};
`ifdef AES3_TX_UNDERFLOW_MUTE_EN
    tv[2] = '{1'b0, 24'h0, 24'h0, 24'h000000, 24'h000000, 1'b1, 1'b1};
`else
    tv[2] = '{1'b0, 24'h0, 24'h0, 24'h123456, 24'h654321, 1'b0, 1'b1};
`endif
    tv[3] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0};
    tv[4] = '{1'b1, 24'h7FFFFF, 24'hABCDEF, 24'h7FFFFF, 24'hABCDEF, 1'b0, 1'b0};
`ifdef AES3_TX_UNDERFLOW_MUTE_EN
    tv[5] = '{1'b0, 24'h0, 24'h0, 24'h000000, 24'h000000, 1'b1, 1'b1};
`else
    tv[5] = '{1'b0, 24'h0, 24'h0, 24'h7FFFFF, 24'hABCDEF, 1'b0, 1'b1};
`endif

    @(negedge mck);
    do_reset(3);
    uf_count = 0;
    bs_count = 0;
    run(2 * FRM, 0);
    chk("idle_underflow_count", 32'(uf_count), 32'd2);
    chk("idle_block_start_count", 32'(bs_count), 32'd1);

    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      run_to(100);
      step(1'b0, tv[i].give, tv[i].l, tv[i].r);
      run_to(0);
      step(1'b0, 1'b0, 24'h0, 24'h0);
      chk("tbl_underflow", 32'(last_uf), 32'(tv[i].euf));
      dc0 = dec_count;
      run(FRM - 1, 0);
      chk("tbl_decoded", 32'(dec_count), 32'(dc0 + 1));
      chk("tbl_l", 32'(dec_last.l), 32'(tv[i].el));
      chk("tbl_r", 32'(dec_last.r), 32'(tv[i].er));
      chk("tbl_v", 32'(dec_last.v), 32'(tv[i].ev));
    end

    // Offer lands in the load cycle itself while holding is empty.
    run_to(0);
    step(1'b0, 1'b1, 24'h0A0B0C, 24'h0D0E0F);
    chk("loadcycle_underflow", 32'(last_uf), 32'd1);
    run_to(128);
    chk("loadcycle_ready_low", 32'(sample_ready), 32'd0);
    run_to(0);
    run(FRM, 0);
    chk("loadcycle_next_l", 32'(dec_last.l), 32'h0A0B0C);
    chk("loadcycle_next_r", 32'(dec_last.r), 32'h0D0E0F);

    // Reset in the middle of frame 5, at UI 70.
    do_reset(2);
    run(5 * FRM + 70 * CPU, 0);
    do_reset(2);
    bs_count = 0;
    dc0 = dec_count;
    run(FRM + 4, 0);
    chk("restart_block_start", 32'(bs_count), 32'd1);
    chk("restart_decoded", 32'(dec_count), 32'(dc0 + 1));
    chk("restart_is_z", 32'(dec_z), 32'd1);

    // One full channel-status block of continuous random samples.
    run_to(1);
    bs_count = 0;
    uf_count = 0;
    run(192 * FRM, 1);
    chk("block_start_per_block", 32'(bs_count), 32'd1);
    chk("stream_no_underflow", 32'(uf_count), 32'd0);

    run(20 * FRM, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes3_tx.md
Name: aes3_tx

Overview:
- AES3 transmitter, the transmit-side counterpart of aes3_rx.
- Accepts stereo 24-bit PCM frames through a valid/ready handshake and emits a biphase-mark-coded AES3 line on a single output.
- Builds preambles, V/U/C/P bits and the 192-frame channel-status block.
- Clocked by mck; drives the digital out of the 701ES board from the same sample stream that feeds the DAC path.

Parameters:
- CLK_PER_UI, 2, mck cycles per AES3 unit interval (UI); 128 UI per frame, so mck = 128*CLK_PER_UI*fs; legal range 1..16.
- CS_BYTE0, 8'h01, channel-status byte 0, sent LSB first in frames 0..7 of each block; all later C bits are 0.

Ports:
- mck  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample_l  input  24  left sample, two's complement.
- sample_r  input  24  right sample, two's complement.
- sample_valid  input  1  sample_l/sample_r valid.
- sample_ready  output  1  holding register empty.
- aes3  output  1  biphase-mark line output.
- block_start  output  1  one-mck pulse when a Z-preamble frame begins.
- underflow  output  1  one-mck pulse when a frame starts with no sample held.

Behaviour:
- Single clock, mck. Reset is synchronous and active-high on reset, sampled on the mck rising edge.
- Reset values: aes3=0, block_start=0, underflow=0, holding register empty (sample_ready=1), frame counter=0, UI counter=127, line level=0.
- UI tick: divider counts 0..CLK_PER_UI-1 and ticks on wrap. All line activity advances only on ticks; aes3 changes only on tick cycles.
- UI counter: 0..127 per frame, wraps at 127.
  - Slot = ui_cnt[6:1]. Slots 0-31 are the left subframe, 32-63 the right.
  - First tick after reset sets ui_cnt=0 and starts frame 0.
- Handshake:
  - sample_ready = holding register empty.
  - Accept when sample_valid && sample_ready; hold both channels.
  - Holding register is single-entry, with no bypass.
- Frame load: occurs in the tick cycle where ui_cnt wraps 127->0 (including the first tick after reset).
  - If holding was full before that cycle, copy it to the transmit registers and clear it.
  - Otherwise assert underflow for that cycle (see Optional Feature).
  - An accept in the load cycle fills holding and is transmitted in the following frame.
  - Latency: a sample accepted at least one cycle before a load is transmitted in that frame.
- Subframe layout, each slot 2 UI:
  - Slots 0-3: preamble.
  - Slots 4-27: sample bits, LSB first (bit0 at slot 4).
  - Slot 28: V. Slot 29: U=0. Slot 30: C. Slot 31: P.
  - P gives even parity over slots 4-31 of that subframe.
- Preambles, 8 UI levels given for a prior line level of 0 (inverted if the prior level is 1):
  - Z = 11101000: left subframe of frame 0.
  - X = 11100010: left subframe of frames 1-191.
  - Y = 11100100: every right subframe.
- Biphase mark for data slots:
  - Line toggles at the start of every slot.
  - Line toggles again at mid-slot (second UI) when the bit is 1.
- Frame counter: 0..191, increments at each load, wraps 191->0. block_start pulses at the load cycle when the frame counter is 0.
- C bit: CS_BYTE0[n] for frame n<8, else 0. The left and right subframes carry the same C bit.
- Reset mid-frame:
  - aes3=0 on the next cycle.
  - Holding register cleared; any pending sample is lost.
  - Transmission restarts with Z at frame 0.
- CLK_PER_UI=1: a tick occurs every cycle; all rules are unchanged.

Optional Feature:
- Macro: AES3_TX_UNDERFLOW_MUTE_EN.
- Defined: on underflow, the transmit registers load 24'h0 for both channels and V=1 in both subframes of that frame. A normal load sets V=0.
- Undefined: on underflow, the previous transmit samples are repeated with V=0. After reset the previous samples are 0.
- underflow pulses in both builds.

Test Plan:
- Reset, then idle for 2 frames (CLK_PER_UI=2) -> aes3=0 during reset; sample_ready=1; first UI after release starts Z (line 1,1,1,0,1,0,0,0); underflow pulse at mck cycles 0 and 256 after release; block_start at cycle 0.
- Accept L=24'h000001, R=24'h800000 before the frame-1 load -> frame 1 decodes L bit0=1 and P=1, R bit23=1 and P=1; all other audio bits 0; preamble X then Y.
- CS_BYTE0=8'h05, samples streamed continuously -> decoded C=1 in frames 0 and 2 only; block_start every 192 frames (49152 mck cycles); Z only at those frames; no underflow.
- Stop supplying samples after L=24'h123456 -> with AES3_TX_UNDERFLOW_MUTE_EN: next frame carries 0 with V=1; without it: 24'h123456 is repeated with V=0; underflow pulses in both builds.
- Assert sample_valid exactly in a load cycle with holding empty -> underflow in that frame; the sample appears in the next frame; sample_ready=0 until the next load.
- Assert reset at ui_cnt=70 of frame 5 -> aes3=0 next cycle; frame counter 0; the next output frame begins with Z.
